// File: rtl/move_sequencer.sv
// move_sequencer
// New-move sequencer for the Othello datapath. It scans 1..8 directions in
// the fixed order U, D, L, R, UL, UR, DL, DR. It runs the validator on every
// direction, then runs the flipper only on directions that validated.
// A per-wait watchdog ends the move if a validator or flipper never answers.
module move_sequencer #(
    parameter int NUM_DIRS = 8,
    parameter int STRIDE   = 10,
    parameter int STEP_W   = 5,
    parameter int TIMEOUT  = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                s_done_vali,
    input  logic                s_done_flip,
    input  logic                dir_status_in,
    output logic [STEP_W-1:0]   step_o,
    output logic                step_sign_o,
    output logic                ld_vali_o,
    output logic                start_vali,
    output logic                ld_flip_o,
    output logic                start_flip,
    output logic [NUM_DIRS-1:0] dir_mask_o,
    output logic                mv_valid_o,
    output logic                timeout_o,
    output logic                nm_done_o
);

    localparam int DIR_W = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_DIRS - 1);
    // The watchdog fires at the end of the TIMEOUT-th wait cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_V_LOAD = 3'd1,
        S_V_WAIT = 3'd2,
        S_F_SCAN = 3'd3,
        S_F_LOAD = 3'd4,
        S_F_WAIT = 3'd5,
        S_FINAL  = 3'd6
    } state_t;

    state_t                r_state;
    logic [DIR_W-1:0]      r_dir_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic [STEP_W-1:0]     r_step;
    logic                  r_sign;
    logic                  r_ld_vali;
    logic                  r_ld_flip;
    logic [NUM_DIRS-1:0]   r_mask;
    logic                  r_mv_valid;
    logic                  r_timeout;
    logic                  r_nm_done;

    logic                  w_dir_last;
    logic [DIR_W-1:0]      w_dir_next;
    logic                  w_wd_expire;
    logic                  w_mask_hit;

    // Step magnitude and sign ({magnitude, sign}) for a direction index.
    function automatic logic [STEP_W:0] dir_step(input logic [DIR_W-1:0] idx);
        logic [STEP_W:0] v;
        case (3'(idx))
            3'd0:    v = {STEP_W'(STRIDE),     1'b1};  // U
            3'd1:    v = {STEP_W'(STRIDE),     1'b0};  // D
            3'd2:    v = {STEP_W'(1),          1'b1};  // L
            3'd3:    v = {STEP_W'(1),          1'b0};  // R
            3'd4:    v = {STEP_W'(STRIDE + 1), 1'b1};  // UL
            3'd5:    v = {STEP_W'(STRIDE - 1), 1'b1};  // UR
            3'd6:    v = {STEP_W'(STRIDE - 1), 1'b0};  // DL
            3'd7:    v = {STEP_W'(STRIDE + 1), 1'b0};  // DR
            default: v = {{STEP_W{1'b0}},      1'b0};
        endcase
        return v;
    endfunction

    assign w_dir_last  = (r_dir_idx == LAST_DIR);
    assign w_dir_next  = r_dir_idx + DIR_W'(1);
    assign w_wd_expire = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
    assign w_mask_hit  = r_mask[r_dir_idx];

    assign step_o      = r_step;
    assign step_sign_o = r_sign;
    assign ld_vali_o   = r_ld_vali;
    assign start_vali  = r_ld_vali;
    assign ld_flip_o   = r_ld_flip;
    assign start_flip  = r_ld_flip;
    assign dir_mask_o  = r_mask;
    assign mv_valid_o  = r_mv_valid;
    assign timeout_o   = r_timeout;
    assign nm_done_o   = r_nm_done;

    // Sequencer FSM; every output is a register loaded on the edge that enters its state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_dir_idx  <= '0;
            r_cnt      <= '0;
            r_step     <= '0;
            r_sign     <= 1'b0;
            r_ld_vali  <= 1'b0;
            r_ld_flip  <= 1'b0;
            r_mask     <= '0;
            r_mv_valid <= 1'b0;
            r_timeout  <= 1'b0;
            r_nm_done  <= 1'b0;
        end else begin
            // Strobes and the completion pulse last a single cycle.
            r_ld_vali <= 1'b0;
            r_ld_flip <= 1'b0;
            r_nm_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_dir_idx         <= '0;
                        r_mask            <= '0;
                        r_mv_valid        <= 1'b0;
                        r_timeout         <= 1'b0;
                        {r_step, r_sign}  <= dir_step('0);
                        r_ld_vali         <= 1'b1;
                        r_state           <= S_V_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_V_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= S_V_WAIT;
                end
                S_V_WAIT: begin
                    // A done in the expiry cycle still counts: done is tested first.
                    if (s_done_vali) begin
                        r_mask[r_dir_idx] <= dir_status_in;
                        if (w_dir_last) begin
                            r_dir_idx <= '0;
                            r_state   <= S_F_SCAN;
                        end else begin
                            r_dir_idx        <= w_dir_next;
                            {r_step, r_sign} <= dir_step(w_dir_next);
                            r_ld_vali        <= 1'b1;
                            r_state          <= S_V_LOAD;
                        end
                    end else if (w_wd_expire) begin
                        r_timeout  <= 1'b1;
                        r_mv_valid <= 1'b0;
                        r_nm_done  <= 1'b1;
                        r_state    <= S_FINAL;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_F_SCAN: begin
                    if (w_mask_hit) begin
                        {r_step, r_sign} <= dir_step(r_dir_idx);
                        r_ld_flip        <= 1'b1;
                        r_state          <= S_F_LOAD;
                    end else if (w_dir_last) begin
                        r_mv_valid <= |r_mask;
                        r_nm_done  <= 1'b1;
                        r_state    <= S_FINAL;
                    end else begin
                        r_dir_idx <= w_dir_next;
                    end
                end
                S_F_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= S_F_WAIT;
                end
                S_F_WAIT: begin
                    if (s_done_flip) begin
                        if (w_dir_last) begin
                            r_mv_valid <= |r_mask;
                            r_nm_done  <= 1'b1;
                            r_state    <= S_FINAL;
                        end else begin
                            r_dir_idx <= w_dir_next;
                            r_state   <= S_F_SCAN;
                        end
                    end else if (w_wd_expire) begin
                        r_timeout  <= 1'b1;
                        r_mv_valid <= 1'b0;
                        r_nm_done  <= 1'b1;
                        r_state    <= S_FINAL;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FINAL: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: a move-level reference model queues the
// expected strobes and completion; a monitor pops and compares whenever the
// DUT strobes a responder or signals completion.
module tb_move_sequencer;

    localparam int ND     = 8;
    localparam int STRIDE = 10;
    localparam int STEP_W = 5;
    localparam int TO     = 16;
    localparam int NEVER  = TO + 1;

    logic clock = 1'b0;
    logic reset, enable, s_done_vali, s_done_flip, dir_status_in;
    logic [STEP_W-1:0] step_o;
    logic step_sign_o, ld_vali_o, start_vali, ld_flip_o, start_flip;
    logic [ND-1:0] dir_mask_o;
    logic mv_valid_o, timeout_o, nm_done_o;

    always #5 clock = ~clock;

    move_sequencer #(.NUM_DIRS(ND), .STRIDE(STRIDE), .STEP_W(STEP_W), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .s_done_vali(s_done_vali), .s_done_flip(s_done_flip), .dir_status_in(dir_status_in),
        .step_o(step_o), .step_sign_o(step_sign_o),
        .ld_vali_o(ld_vali_o), .start_vali(start_vali),
        .ld_flip_o(ld_flip_o), .start_flip(start_flip),
        .dir_mask_o(dir_mask_o), .mv_valid_o(mv_valid_o),
        .timeout_o(timeout_o), .nm_done_o(nm_done_o)
    );

    // kind: 0 validator strobe, 1 flipper strobe, 2 move completion
    typedef struct {
        int kind;
        int cyc;
        int mag;
        int sgn;
        int mask;
        int mv;
        int to;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  mag_t[ND];
    int  sgn_t[ND];
    bit  vstat[ND];
    int  vdel[ND];
    int  fdel[ND];
    bit  spur = 1'b0;
    bit  f_hold = 1'b0;
    int  exp_mask, exp_mv, exp_to;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int decode(input int m, input int s);
        for (int d = 0; d < ND; d++)
            if (mag_t[d] == m && sgn_t[d] == s) return d;
        return 0;
    endfunction

    // Reference model: walk the move's rules using the responder timings.
    // Times are cycle numbers relative to the enable-sampling edge (cycle 1 = first V_LOAD).
    task automatic build_expect(input int base);
        int t, mask, to;
        ev_t e;
        t = 1; mask = 0; to = 0;
        for (int d = 0; d < ND; d++) begin
            e = '{0, base + t, mag_t[d], sgn_t[d], 0, 0, 0};
            exp_q.push_back(e);
            if (vdel[d] > TO) begin
                to = 1; t = t + TO + 1;
                break;
            end
            if (vstat[d]) mask = mask | (1 << d);
            t = t + 1 + vdel[d];
        end
        if (to == 0) begin
            for (int d = 0; d < ND; d++) begin
                if (((mask >> d) & 1) != 0) begin
                    e = '{1, base + t + 1, mag_t[d], sgn_t[d], 0, 0, 0};
                    exp_q.push_back(e);
                    if (fdel[d] > TO) begin
                        to = 1; t = t + 2 + TO;
                        break;
                    end
                    t = t + 2 + fdel[d];
                end else begin
                    t = t + 1;
                end
            end
        end
        exp_mask = mask;
        exp_mv   = (to == 0 && mask != 0) ? 1 : 0;
        exp_to   = to;
        e = '{2, base + t, 0, 0, exp_mask, exp_mv, exp_to};
        exp_q.push_back(e);
    endtask

    // Monitor: compare every strobe / completion against the queue head.
    always @(negedge clock) begin : monitor
        ev_t e;
        if (!reset && (ld_vali_o || start_vali || ld_flip_o || start_flip || nm_done_o)) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output vali=%0b flip=%0b done=%0b cycle=%0d expected none",
                         ld_vali_o, ld_flip_o, nm_done_o, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("ld_vali_o", int'(ld_vali_o), (e.kind == 0) ? 1 : 0);
                chk("start_vali", int'(start_vali), (e.kind == 0) ? 1 : 0);
                chk("ld_flip_o", int'(ld_flip_o), (e.kind == 1) ? 1 : 0);
                chk("start_flip", int'(start_flip), (e.kind == 1) ? 1 : 0);
                chk("nm_done_o", int'(nm_done_o), (e.kind == 2) ? 1 : 0);
                if (e.kind == 2) begin
                    chk("dir_mask_o", int'(dir_mask_o), e.mask);
                    chk("mv_valid_o", int'(mv_valid_o), e.mv);
                    chk("timeout_o", int'(timeout_o), e.to);
                end else begin
                    chk("step_o", int'(step_o), e.mag);
                    chk("step_sign_o", int'(step_sign_o), e.sgn);
                end
            end
        end
    end

    // Validator responder: answers each load after vdel cycles (never if > TO).
    initial begin : vresp
        s_done_vali = 1'b0;
        dir_status_in = 1'b0;
        forever begin
            @(negedge clock);
            if (ld_vali_o && !reset) begin : vload
                int d, k;
                d = decode(int'(step_o), int'(step_sign_o));
                k = vdel[d];
                if (spur) begin
                    s_done_vali = 1'b1;
                    dir_status_in = ~vstat[d];
                end
                @(posedge clock); #1;
                s_done_vali = 1'b0;
                if (k <= TO) begin
                    for (int j = 1; j < k; j++) begin
                        @(posedge clock); #1;
                    end
                    s_done_vali = 1'b1;
                    dir_status_in = vstat[d];
                    @(posedge clock); #1;
                    s_done_vali = 1'b0;
                end
            end
        end
    end

    // Flipper responder: pulsed done after fdel cycles, or done held high in hold mode.
    initial begin : fresp
        s_done_flip = 1'b0;
        forever begin
            @(negedge clock);
            if (f_hold) begin
                s_done_flip = 1'b1;
            end else begin
                s_done_flip = 1'b0;
                if (ld_flip_o && !reset) begin : fload
                    int d, k;
                    d = decode(int'(step_o), int'(step_sign_o));
                    k = fdel[d];
                    if (k <= TO) begin
                        for (int j = 0; j < k; j++) begin
                            @(posedge clock); #1;
                        end
                        s_done_flip = 1'b1;
                        @(posedge clock); #1;
                        s_done_flip = 1'b0;
                    end
                end
            end
        end
    end

    task automatic set_all(input bit vs, input int vd, input int fd);
        for (int d = 0; d < ND; d++) begin
            vstat[d] = vs; vdel[d] = vd; fdel[d] = fd;
        end
    endtask

    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 19);
        if (r < 13) return $urandom_range(1, 3);
        if (r < 16) return TO;
        if (r < 17) return NEVER;
        return $urandom_range(4, 9);
    endfunction

    // One move: optional enable pulse in V_WAIT, optional reset during F_WAIT.
    task automatic run_move(input bit pulse_en, input bit do_reset);
        int base, n;
        @(negedge clock);
        enable = 1'b1;
        base = cyc;
        build_expect(base);
        @(negedge clock);
        enable = 1'b0;
        chk("start_clears_mask", int'(dir_mask_o), 0);
        chk("start_clears_mv_valid", int'(mv_valid_o), 0);
        chk("start_clears_timeout", int'(timeout_o), 0);
        if (pulse_en) begin
            @(negedge clock);
            enable = 1'b1;
            @(negedge clock);
            enable = 1'b0;
        end
        if (do_reset) begin
            n = 0;
            while (!ld_flip_o && n < 400) begin
                @(negedge clock); n++;
            end
            chk("reach_flip_before_reset", (n < 400) ? 1 : 0, 1);
            repeat (3) @(negedge clock);
            #2 reset = 1'b1;
            #1;
            chk("async_reset_step", int'(step_o), 0);
            chk("async_reset_sign", int'(step_sign_o), 0);
            chk("async_reset_mask", int'(dir_mask_o), 0);
            chk("async_reset_strobes", int'({ld_vali_o, start_vali, ld_flip_o, start_flip}), 0);
            chk("async_reset_flags", int'({mv_valid_o, timeout_o, nm_done_o}), 0);
            exp_q.delete();
            @(negedge clock);
            reset = 1'b0;
            repeat (6) @(negedge clock);
            chk("no_done_after_reset", exp_q.size(), 0);
        end else begin
            n = 0;
            while (!nm_done_o && n < 400) begin
                @(negedge clock); n++;
            end
            chk("move_completes", (n < 400) ? 1 : 0, 1);
            @(negedge clock);
            chk("retain_mask", int'(dir_mask_o), exp_mask);
            chk("retain_mv_valid", int'(mv_valid_o), exp_mv);
            chk("retain_timeout", int'(timeout_o), exp_to);
            chk("done_one_cycle", int'(nm_done_o), 0);
            chk("queue_drained", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin : stim
        mag_t = '{STRIDE, STRIDE, 1, 1, STRIDE + 1, STRIDE - 1, STRIDE - 1, STRIDE + 1};
        sgn_t = '{1, 0, 1, 0, 1, 1, 0, 0};
        reset = 1'b1;
        enable = 1'b0;
        set_all(1'b0, 1, 1);
        #12;
        chk("reset_step", int'(step_o), 0);
        chk("reset_sign", int'(step_sign_o), 0);
        chk("reset_strobes", int'({ld_vali_o, start_vali, ld_flip_o, start_flip}), 0);
        chk("reset_mask", int'(dir_mask_o), 0);
        chk("reset_flags", int'({mv_valid_o, timeout_o, nm_done_o}), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // No valid directions, single-cycle responders: done in cycle 3*ND+1.
        set_all(1'b0, 1, 1);
        run_move(1'b0, 1'b0);

        // Only UR and DR valid: flips at (9,1) then (11,0).
        set_all(1'b0, 1, 1);
        vstat[5] = 1'b1; vstat[7] = 1'b1;
        run_move(1'b0, 1'b0);

        // Validator silent on L: watchdog ends the move, partial mask kept.
        set_all(1'b1, 1, 1);
        vstat[1] = 1'b0;
        vdel[2] = NEVER;
        run_move(1'b0, 1'b0);

        // Done in the final wait cycle still wins over the watchdog.
        set_all(1'b1, 1, 1);
        vdel[3] = TO;
        fdel[6] = TO;
        run_move(1'b0, 1'b0);

        // Enable pulsed during V_WAIT and spurious done during V_LOAD are ignored.
        set_all(1'b0, 1, 1);
        vdel[0] = 3;
        spur = 1'b1;
        run_move(1'b1, 1'b0);
        spur = 1'b0;

        // Reset during F_WAIT, then a fresh move.
        set_all(1'b1, 1, 1);
        fdel[0] = NEVER;
        run_move(1'b0, 1'b1);
        set_all(1'b0, 1, 1);
        vstat[0] = 1'b1; vstat[4] = 1'b1;
        run_move(1'b0, 1'b0);

        // Flipper done held high, every direction valid.
        set_all(1'b1, 1, 1);
        f_hold = 1'b1;
        run_move(1'b0, 1'b0);
        f_hold = 1'b0;

        // Randomized moves.
        for (int m = 0; m < 40; m++) begin
            for (int d = 0; d < ND; d++) begin
                vstat[d] = 1'($urandom_range(0, 1));
                vdel[d]  = pick_delay();
                fdel[d]  = pick_delay();
            end
            spur = 1'($urandom_range(0, 1));
            run_move(1'($urandom_range(0, 1)) && (vdel[0] >= 3), 1'b0);
        end
        spur = 1'b0;

        repeat (4) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Parametrised new-move sequencer for the Othello datapath. It replaces the fixed four-direction new-move controller with one that handles 1–8 directions, including diagonals, on a configurable board stride. It sequences the validator over every direction, then runs the flipper only on directions that validated. A done-handshake watchdog ensures a stuck validator or flipper cannot hang the main controller.

## Interface
Parameters:
- NUM_DIRS, 8, number of directions scanned (1..8). Order is fixed: U, D, L, R, UL, UR, DL, DR; index 0 = U.
- STRIDE, 10, board-address distance between vertically adjacent squares.
- STEP_W, 5, width of step_o. Must hold STRIDE+1.
- TIMEOUT, 255, maximum cycles spent waiting for one done. 0 disables the watchdog.

Ports:
- clock  in  1  system clock (CLOCK_50); all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately
- enable  in  1  new_move request from main controller; sampled only in IDLE
- s_done_vali  in  1  validator done; sampled only in V_WAIT
- s_done_flip  in  1  flipper done; sampled only in F_WAIT
- dir_status_in  in  1  validator verdict for the current direction; valid with s_done_vali
- step_o  out  STEP_W  step magnitude for the current direction
- step_sign_o  out  1  1 = subtract step (toward U/L), 0 = add
- ld_vali_o / start_vali  out  1  one-cycle load and start strobe to the validator
- ld_flip_o / start_flip  out  1  one-cycle load and start strobe to the flipper
- dir_mask_o  out  NUM_DIRS  per-direction validation result of the last move
- mv_valid_o  out  1  last move legal (OR of dir_mask_o)
- timeout_o  out  1  last move aborted by the watchdog
- nm_done_o  out  1  one-cycle completion pulse

## Operation
- States: IDLE, V_LOAD, V_WAIT, F_SCAN, F_LOAD, F_WAIT, FINAL. Register dir_idx tracks the current direction; a wait counter serves the watchdog.
- Direction encoding as {magnitude, sign}:
  - U {STRIDE,1}, D {STRIDE,0}, L {1,1}, R {1,0}
  - UL {STRIDE+1,1}, UR {STRIDE-1,1}, DL {STRIDE-1,0}, DR {STRIDE+1,0}
- IDLE: on enable=1, go to V_LOAD. At the same edge, clear dir_idx, dir_mask_o, mv_valid_o and timeout_o.
- V_LOAD (1 cycle): drive step for dir_idx; assert ld_vali_o=start_vali=1. Go to V_WAIT.
- V_WAIT: step held; strobes 0. On s_done_vali:
  - mask[dir_idx] <= dir_status_in.
  - If dir_idx = NUM_DIRS-1, set dir_idx=0 and go to F_SCAN.
  - Otherwise increment dir_idx and go to V_LOAD.
- F_SCAN (1 cycle per visited direction):
  - If mask[dir_idx]=1, go to F_LOAD.
  - Else if dir_idx is last, go to FINAL.
  - Else increment dir_idx and stay.
- F_LOAD (1 cycle): drive step for dir_idx; assert ld_flip_o=start_flip=1. Go to F_WAIT.
- F_WAIT: on s_done_flip, go to FINAL if dir_idx is last; otherwise increment dir_idx and go to F_SCAN.
- FINAL (1 cycle): nm_done_o=1; mv_valid_o <= |mask unless timed out. Go to IDLE.
- Watchdog: the counter clears on entering V_WAIT or F_WAIT and increments each wait cycle. When it reaches TIMEOUT without a done, go to FINAL with timeout_o=1 and mv_valid_o=0; dir_mask_o keeps the partial results. Any remaining flips are not performed.
- Retention: mv_valid_o, timeout_o, dir_mask_o, step_o and step_sign_o hold their values until the next accepted enable or load.

## Timing
- Reset values: step_o=0, step_sign_o=0, all strobes 0, dir_mask_o=0, mv_valid_o=0, timeout_o=0, nm_done_o=0, state=IDLE.
- Outputs are Moore-decoded from registered state and registers; no combinational path from any input to any output.
- Strobes last exactly one cycle per direction.
- Done handling:
  - A done asserted during V_LOAD, F_LOAD or any other state is ignored.
  - A done held high for several cycles counts once, because the next WAIT is entered only after a LOAD cycle.
  - Done arriving in the same cycle the watchdog expires: done wins.
- enable asserted outside IDLE is ignored and not queued. enable held high re-triggers one cycle after FINAL.
- Reset asserted mid-move returns to IDLE at once; the partial move is discarded and nm_done_o is not pulsed.
- Latency with responders that give done in the first wait cycle, counted from the enable-sampling edge with V = number of valid directions:
  - FINAL occurs in cycle 2·NUM_DIRS + NUM_DIRS + 2·V + 1.
  - NUM_DIRS=4, V=0 gives cycle 13.

## Test plan
- NUM_DIRS=4, all dir_status_in=0, 1-cycle responders -> four validator strobes with steps (10,1),(10,0),(1,1),(1,0); zero flip strobes; nm_done_o in cycle 13; mv_valid_o=0; dir_mask_o=0000.
- NUM_DIRS=8, only UR and DR valid -> dir_mask_o=8'b1010_0000 (bit 5 UR, bit 7 DR); exactly two flip strobes with steps (9,1) then (11,0); mv_valid_o=1.
- TIMEOUT=16, validator never responds on direction L -> timeout_o=1 in FINAL 17 cycles after entering V_WAIT for L; mv_valid_o=0; no flip strobes; next enable clears timeout_o.
- enable pulsed in V_WAIT, plus a spurious s_done_vali in V_LOAD -> no second move started; the spurious done is ignored; sequence and latency match the first scenario.
- reset asserted during F_WAIT, then a new enable -> all outputs 0 asynchronously; no nm_done_o; the fresh move completes normally.
- s_done_flip held high continuously, all four directions valid -> each flip strobe is separated by F_SCAN, F_LOAD and F_WAIT; exactly four flip strobes.
